// File: rtl/aes_block_loader_pkg.sv
// Shared definitions for the AES block loader: FSM encodings, block geometry and index helpers.
package aes_block_loader_pkg;

   typedef enum logic [1:0] {
      LOAD_KEY  = 2'd0,
      LOAD_DATA = 2'd1,
      HOLD      = 2'd2
   } ldr_state_t;

   localparam int BLOCK_BYTES = 16;
   localparam int MAT_DIM     = 4;

   localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

   // FIPS-197 column-major placement: byte n lands at [n mod 4][n div 4].
   function automatic logic [1:0] idx_row(input logic [3:0] n);
      return n[1:0];
   endfunction

   function automatic logic [1:0] idx_col(input logic [3:0] n);
      return n[3:2];
   endfunction

endpackage

// File: rtl/aes_block_loader_ctrl.sv
// Loader control: LOAD_KEY/LOAD_DATA/HOLD FSM, byte counter and matrix write enables.
// With AES_BLOCK_LOADER_KEY_REUSE_EN defined, key_reload selects whether the next block reloads the key.
module aes_loader_ctrl
   import aes_block_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       out_ready,
`ifdef AES_BLOCK_LOADER_KEY_REUSE_EN
   input  logic       key_reload,
`endif
   output logic       in_ready,
   output logic       out_valid,
   output logic       key_we,
   output logic       data_we,
   output logic [3:0] idx
);

   ldr_state_t state_q;
   logic [3:0] n_q;
   logic [3:0] n_d;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       accept;
   ldr_state_t after_xfer;

   assign accept  = in_valid & in_ready_q;
   assign n_d     = n_q + 4'd1;
   assign key_we  = accept & (state_q == LOAD_KEY);
   assign data_we = accept & (state_q == LOAD_DATA);
   assign idx     = n_q;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

`ifdef AES_BLOCK_LOADER_KEY_REUSE_EN
   assign after_xfer = key_reload ? LOAD_KEY : LOAD_DATA;
`else
   assign after_xfer = LOAD_KEY;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD_KEY;
         n_q         <= 4'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            LOAD_KEY: begin
               if (accept) begin
                  n_q <= n_d;
                  if (n_q == LAST_IDX) state_q <= LOAD_DATA;
               end
            end
            LOAD_DATA: begin
               if (accept) begin
                  n_q <= n_d;
                  if (n_q == LAST_IDX) begin
                     state_q     <= HOLD;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q     <= after_xfer;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= LOAD_KEY;
               n_q         <= 4'd0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/aes_block_loader.sv
// Serial-to-matrix loader feeding an AES core: 16 key bytes then 16 data bytes, held until consumed.
// Optional key reuse (key_reload port) is enabled by defining AES_BLOCK_LOADER_KEY_REUSE_EN.
module aes_block_loader
   import aes_block_loader_pkg::*;
(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [7:0]                            in_byte,
   input  logic                                  in_valid,
   output logic                                  in_ready,
`ifdef AES_BLOCK_LOADER_KEY_REUSE_EN
   input  logic                                  key_reload,
`endif
   output logic [0:MAT_DIM-1][0:MAT_DIM-1][7:0]  key,
   output logic [0:MAT_DIM-1][0:MAT_DIM-1][7:0]  data,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   logic [0:MAT_DIM-1][0:MAT_DIM-1][7:0] key_q, key_d;
   logic [0:MAT_DIM-1][0:MAT_DIM-1][7:0] data_q, data_d;
   logic       key_we;
   logic       data_we;
   logic [3:0] idx;
   logic [1:0] row;
   logic [1:0] col;

   aes_loader_ctrl u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .out_ready (out_ready),
`ifdef AES_BLOCK_LOADER_KEY_REUSE_EN
      .key_reload(key_reload),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .key_we    (key_we),
      .data_we   (data_we),
      .idx       (idx)
   );

   assign row = idx_row(idx);
   assign col = idx_col(idx);

   // Only the addressed element changes; everything else keeps the previous block's value.
   always_comb begin
      key_d  = key_q;
      data_d = data_q;
      if (key_we)  key_d[row][col]  = in_byte;
      if (data_we) data_d[row][col] = in_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q  <= '0;
         data_q <= '0;
      end else begin
         key_q  <= key_d;
         data_q <= data_d;
      end
   end

   assign key  = key_q;
   assign data = data_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: cycle model plus a scoreboard of completed blocks.
module tb_aes_block_loader;

   logic                         clk;
   logic                         rst;
   logic [7:0]                   in_byte;
   logic                         in_valid;
   logic                         in_ready;
   logic                         key_reload;
   logic [0:3][0:3][7:0]         key;
   logic [0:3][0:3][7:0]         data;
   logic                         out_valid;
   logic                         out_ready;

   aes_block_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_byte   (in_byte),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef AES_BLOCK_LOADER_KEY_REUSE_EN
      .key_reload(key_reload),
`endif
      .key       (key),
      .data      (data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] k;
      logic [127:0] d;
   } blk_t;

   blk_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   // model: ms 0=loading key, 1=loading data, 2=holding
   int                   ms;
   logic [3:0]           mn;
   logic [0:3][0:3][7:0] m_key;
   logic [0:3][0:3][7:0] m_data;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      blk_t e;
      if (!rst && ms == 2 && out_ready) begin
         if (sb.size() == 0) begin
            check_eq("xfer_unexpected", 128'd1, 128'd0);
         end else begin
            e = sb.pop_front();
            check_eq("xfer_key", key, e.k);
            check_eq("xfer_data", data, e.d);
         end
      end
      if (rst) begin
         ms = 0; mn = 4'd0; m_key = '0; m_data = '0;
         sb.delete();
      end else begin
         case (ms)
            0: if (in_valid) begin
               m_key[mn % 4][mn / 4] = in_byte;
               if (mn == 4'd15) ms = 1;
               mn = mn + 4'd1;
            end
            1: if (in_valid) begin
               m_data[mn % 4][mn / 4] = in_byte;
               if (mn == 4'd15) begin
                  ms = 2;
                  e.k = m_key; e.d = m_data;
                  sb.push_back(e);
               end
               mn = mn + 4'd1;
            end
            default: if (out_ready) begin
`ifdef AES_BLOCK_LOADER_KEY_REUSE_EN
               ms = key_reload ? 0 : 1;
`else
               ms = 0;
`endif
            end
         endcase
      end
      @(posedge clk);
      #1;
      check_eq("in_ready", 128'(in_ready), 128'(ms != 2));
      check_eq("out_valid", 128'(out_valid), 128'(ms == 2));
      check_eq("key", key, m_key);
      check_eq("data", data, m_data);
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1; in_byte = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic transfer();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [127:0] fips_key;
   logic [127:0] fips_pt;
   logic [0:3][0:3][7:0] exp_m;

   initial begin
      rst = 1'b1; in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b0; key_reload = 1'b1;
      ms = 0; mn = 4'd0; m_key = '0; m_data = '0;
      tick(); tick();
      rst = 1'b0;

      // incrementing stream, in_valid held high
      for (int i = 0; i < 32; i++) send(8'(i));
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            check_eq("key_formula", 128'(key[r][c]), 128'(4*c + r));
            check_eq("data_formula", 128'(data[r][c]), 128'(8'h10 + 4*c + r));
         end

      // stall in HOLD with bytes offered
      in_valid = 1'b1; in_byte = 8'hAA;
      for (int i = 0; i < 10; i++) tick();
      in_valid = 1'b0;
      transfer();
      tick();

      // in_valid toggled every other cycle, out_ready held high throughout
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         in_valid = (i % 2 == 0);
         in_byte  = 8'($urandom_range(0, 255));
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      out_ready = 1'b0;
      tick();

      // reset mid-block after 20 accepted bytes, with a byte offered at the reset edge
      for (int i = 0; i < 20; i++) send(8'($urandom_range(1, 255)));
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_byte = 8'h5A;
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check_eq("rst_key_zero", key, 128'd0);
      check_eq("rst_data_zero", data, 128'd0);
      tick();

      // a full random block after reset, final data byte offered with out_ready high
      for (int i = 0; i < 31; i++) send(8'($urandom_range(0, 255)));
      out_ready = 1'b1;
      send(8'hC3);
      tick();
      out_ready = 1'b0;
      tick();

`ifdef AES_BLOCK_LOADER_KEY_REUSE_EN
      fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_pt  = 128'h3243f6a8885a308d313198a2e0370734;
      for (int i = 0; i < 16; i++) send(fips_key[127 - 8*i -: 8]);
      for (int i = 0; i < 16; i++) send(fips_pt[127 - 8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) exp_m[r][c] = fips_key[127 - 8*(4*c + r) -: 8];
      check_eq("fips_key", key, exp_m);
      key_reload = 1'b0;
      transfer();
      key_reload = 1'b1;
      for (int i = 0; i < 16; i++) send(8'(8'hE0 + i));
      check_eq("reuse_key_kept", key, exp_m);
      check_eq("reuse_out_valid", 128'(out_valid), 128'd1);
      transfer();
      tick();
`else
      fips_key = '0;
      fips_pt  = '0;
      exp_m    = '0;
`endif

      check_eq("sb_drained", 128'(sb.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
